sqxor_issue_arbiter: RTL and testbench

- Round-robin arbiter and sequencer that shares one pipelined square/fold/XOR datapath (operands a, b in; one result out) between NUM_REQ requesters.
- Issues at most one operation per cycle into the fixed-latency, non-stallable datapath.
- Tracks the requester ID of every operation in flight and returns each result tagged with that ID.
- Provides a drain/halt state machine so software can quiesce the datapath, for example before clock gating.

---
 rtl/sqxor_issue_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_sqxor_issue_arbiter.sv | 217 +++++++++++++++++++++
 2 files changed

// File: rtl/sqxor_issue_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : sqxor_issue_arbiter
// Description : Round-robin issue arbiter for a shared, fixed-latency
//               square/fold/XOR datapath, with ID-tagged responses and a
//               RUN/DRAIN/HALTED quiesce state machine.
//               Optional macro SQXOR_ARB_PRIORITY_EN makes requester 0 urgent.
// Revision    : 1.0 - initial release
// ============================================================================
module sqxor_issue_arbiter #(
    parameter int NUM_REQ    = 4,
    parameter int BITWIDTH   = 16,
    parameter int DP_LATENCY = 4
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [NUM_REQ-1:0]              req_valid,
    input  logic [NUM_REQ*BITWIDTH-1:0]     req_a,
    input  logic [NUM_REQ*BITWIDTH-1:0]     req_b,
    output logic [NUM_REQ-1:0]              req_ready,
    output logic [BITWIDTH-1:0]             dp_a,
    output logic [BITWIDTH-1:0]             dp_b,
    input  logic [BITWIDTH-1:0]             dp_result,
    output logic                            resp_valid,
    output logic [$clog2(NUM_REQ)-1:0]      resp_id,
    output logic [BITWIDTH-1:0]             resp_data,
    input  logic                            drain_req,
    output logic                            halted,
    output logic                            busy
);

    localparam int ID_W  = $clog2(NUM_REQ);
    localparam int CNT_W = $clog2(DP_LATENCY + 1);

    localparam logic [1:0] S_RUN    = 2'd0;
    localparam logic [1:0] S_DRAIN  = 2'd1;
    localparam logic [1:0] S_HALTED = 2'd2;

    logic [1:0]            r_state;
    logic [1:0]            w_state_nxt;
    logic [ID_W-1:0]       r_ptr;
    logic [ID_W-1:0]       w_ptr_nxt;
    logic                  w_ptr_upd;
    logic [CNT_W-1:0]      r_inflight;
    logic [DP_LATENCY-1:0] r_tag_v;
    logic [ID_W-1:0]       r_tag_id [DP_LATENCY];

    logic                  w_grant_en;
    logic                  w_found;
    logic                  w_xfer;
    logic [ID_W-1:0]       w_gnt_id;
    logic [NUM_REQ-1:0]    w_rr_valid;
    logic [ID_W:0]         w_idx;

    // Gating with rst_n keeps req_ready and dp_a/dp_b at zero while in reset.
    assign w_grant_en = rst_n && (r_state == S_RUN) && !drain_req;

`ifdef SQXOR_ARB_PRIORITY_EN
    assign w_rr_valid = {req_valid[NUM_REQ-1:1], 1'b0};
`else
    assign w_rr_valid = req_valid;
`endif

    always_comb begin
        w_found  = 1'b0;
        w_gnt_id = '0;
        w_idx    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            w_idx = {1'b0, r_ptr} + (ID_W+1)'(k);
            if (w_idx >= (ID_W+1)'(NUM_REQ)) begin
                w_idx = w_idx - (ID_W+1)'(NUM_REQ);
            end
            if (!w_found && w_rr_valid[w_idx[ID_W-1:0]]) begin
                w_found  = 1'b1;
                w_gnt_id = w_idx[ID_W-1:0];
            end
        end
`ifdef SQXOR_ARB_PRIORITY_EN
        if (req_valid[0]) begin
            w_found  = 1'b1;
            w_gnt_id = '0;
        end
`endif
        if (!w_grant_en) begin
            w_found  = 1'b0;
            w_gnt_id = '0;
        end
    end

    assign w_xfer = w_found;

    always_comb begin
        req_ready = '0;
        if (w_found) begin
            req_ready[w_gnt_id] = 1'b1;
        end
    end

    // Operands are zeroed when idle so the datapath only toggles on real work.
    assign dp_a = w_found ? req_a[int'(w_gnt_id)*BITWIDTH +: BITWIDTH] : '0;
    assign dp_b = w_found ? req_b[int'(w_gnt_id)*BITWIDTH +: BITWIDTH] : '0;

    assign w_ptr_nxt = (w_gnt_id == ID_W'(NUM_REQ - 1)) ? '0 : w_gnt_id + ID_W'(1);

`ifdef SQXOR_ARB_PRIORITY_EN
    assign w_ptr_upd = w_xfer && (w_gnt_id != '0);
`else
    assign w_ptr_upd = w_xfer;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr <= '0;
        end else if (w_ptr_upd) begin
            r_ptr <= w_ptr_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_RUN: begin
                if (drain_req) w_state_nxt = S_DRAIN;
            end
            S_DRAIN: begin
                if (!drain_req)              w_state_nxt = S_RUN;
                else if (r_inflight == '0)   w_state_nxt = S_HALTED;
            end
            S_HALTED: begin
                if (!drain_req) w_state_nxt = S_RUN;
            end
            default: w_state_nxt = S_RUN;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Tag stage k holds the op issued k+1 cycles ago; the last stage lines up
    // with dp_result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tag_v <= '0;
            for (int i = 0; i < DP_LATENCY; i++) begin
                r_tag_id[i] <= '0;
            end
        end else begin
            r_tag_v[0]  <= w_xfer;
            r_tag_id[0] <= w_gnt_id;
            for (int i = 1; i < DP_LATENCY; i++) begin
                r_tag_v[i]  <= r_tag_v[i-1];
                r_tag_id[i] <= r_tag_id[i-1];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_inflight <= '0;
        end else begin
            case ({w_xfer, r_tag_v[DP_LATENCY-1]})
                2'b10:   r_inflight <= r_inflight + CNT_W'(1);
                2'b01:   r_inflight <= r_inflight - CNT_W'(1);
                default: r_inflight <= r_inflight;
            endcase
        end
    end

    assign resp_valid = r_tag_v[DP_LATENCY-1];
    assign resp_id    = r_tag_id[DP_LATENCY-1];
    assign resp_data  = dp_result;
    assign halted     = (r_state == S_HALTED);
    assign busy       = (r_inflight != '0);

endmodule
`default_nettype wire

// File: tb/tb_sqxor_issue_arbiter.sv
`default_nettype none
// Testbench for sqxor_issue_arbiter: directed phases plus random traffic,
// checked against a queue-based model of grants, responses and drain state.
module tb_sqxor_issue_arbiter;

    localparam int N   = 4;
    localparam int BW  = 16;
    localparam int LAT = 4;

    logic            clk;
    logic            rst_n;
    logic [N-1:0]    req_valid;
    logic [N*BW-1:0] req_a;
    logic [N*BW-1:0] req_b;
    logic [N-1:0]    req_ready;
    logic [BW-1:0]   dp_a;
    logic [BW-1:0]   dp_b;
    logic [BW-1:0]   dp_result;
    logic            resp_valid;
    logic [1:0]      resp_id;
    logic [BW-1:0]   resp_data;
    logic            drain_req;
    logic            halted;
    logic            busy;

    sqxor_issue_arbiter #(.NUM_REQ(N), .BITWIDTH(BW), .DP_LATENCY(LAT)) dut (
        .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_a(req_a),
        .req_b(req_b), .req_ready(req_ready), .dp_a(dp_a), .dp_b(dp_b),
        .dp_result(dp_result), .resp_valid(resp_valid), .resp_id(resp_id),
        .resp_data(resp_data), .drain_req(drain_req), .halted(halted),
        .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [BW-1:0] sqx(input logic [BW-1:0] a, input logic [BW-1:0] b);
        logic [31:0] s;
        s = (32'(a) * 32'(a)) ^ (32'(b) * 32'(b));
        return s[15:0] ^ s[31:16];
    endfunction

    // Fixed-latency datapath stand-in.
    logic [BW-1:0] dpq [LAT];
    always @(posedge clk) begin
        dpq[0] <= sqx(dp_a, dp_b);
        for (int i = 1; i < LAT; i++) dpq[i] <= dpq[i-1];
    end
    assign dp_result = dpq[LAT-1];

    typedef struct {
        int          due;
        int          id;
        logic [15:0] data;
    } rsp_t;

    rsp_t q[$];
    int   total = 0;
    int   bad   = 0;
    int   cyc   = 0;
    int   mptr  = 0;
    int   mstate = 0;   // 0 run, 1 drain, 2 halted
    logic d_rand;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic rand_ops();
        for (int i = 0; i < N; i++) begin
            req_a[i*BW +: BW] = BW'($urandom);
            req_b[i*BW +: BW] = BW'($urandom);
        end
    endtask

    // One cycle: drive at negedge, check, then advance the model at posedge.
    task automatic step(input logic [N-1:0] v, input logic d);
        int   eg;
        int   qn;
        int   j;
        logic [BW-1:0] ea;
        logic [BW-1:0] eb;
        req_valid = v;
        drain_req = d;
        #1;
        eg = -1;
        if (mstate == 0 && !d) begin
`ifdef SQXOR_ARB_PRIORITY_EN
            if (v[0]) eg = 0;
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (eg < 0 && j != 0 && v[j]) eg = j;
            end
`else
            for (int k = 0; k < N; k++) begin
                j = (mptr + k) % N;
                if (eg < 0 && v[j]) eg = j;
            end
`endif
        end
        ea = (eg < 0) ? '0 : req_a[eg*BW +: BW];
        eb = (eg < 0) ? '0 : req_b[eg*BW +: BW];
        chk("req_ready", 32'(req_ready), (eg < 0) ? 32'd0 : (32'd1 << eg));
        chk("dp_a", 32'(dp_a), 32'(ea));
        chk("dp_b", 32'(dp_b), 32'(eb));
        qn = q.size();
        chk("busy", 32'(busy), 32'(qn != 0));
        chk("halted", 32'(halted), 32'(mstate == 2));
        if (qn > 0 && q[0].due == cyc) begin
            chk("resp_valid", 32'(resp_valid), 32'd1);
            chk("resp_id", 32'(resp_id), 32'(q[0].id));
            chk("resp_data", 32'(resp_data), 32'(q[0].data));
            void'(q.pop_front());
        end else begin
            chk("resp_valid", 32'(resp_valid), 32'd0);
        end
        if (eg >= 0) begin
            q.push_back('{due: cyc + LAT, id: eg, data: sqx(ea, eb)});
`ifdef SQXOR_ARB_PRIORITY_EN
            if (eg != 0) mptr = (eg + 1) % N;
`else
            mptr = (eg + 1) % N;
`endif
        end
        case (mstate)
            0: if (d) mstate = 1;
            1: if (!d) mstate = 0; else if (qn == 0) mstate = 2;
            default: if (!d) mstate = 0;
        endcase
        @(posedge clk);
        cyc++;
        @(negedge clk);
    endtask

    initial begin
        rst_n = 1'b0;
        req_valid = '0;
        req_a = '0;
        req_b = '0;
        drain_req = 1'b0;
        repeat (2) @(negedge clk);
        #1;
        chk("rst_req_ready", 32'(req_ready), 32'd0);
        chk("rst_dp_a", 32'(dp_a), 32'd0);
        chk("rst_resp_valid", 32'(resp_valid), 32'd0);
        chk("rst_resp_id", 32'(resp_id), 32'd0);
        chk("rst_halted", 32'(halted), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single op from requester 2.
        req_a[2*BW +: BW] = 16'h0003;
        req_b[2*BW +: BW] = 16'h0002;
        chk("sqx_ref", 32'(sqx(req_a[2*BW +: BW], req_b[2*BW +: BW])), 32'h000D);
        step(4'b0100, 1'b0);
        repeat (6) step(4'b0000, 1'b0);

        // Fairness with all requesters active.
        for (int i = 0; i < 8; i++) begin rand_ops(); step(4'b1111, 1'b0); end
        repeat (6) step(4'b0000, 1'b0);

        // Drain under continuous traffic, then resume.
        for (int i = 0; i < 10; i++) begin rand_ops(); step(4'b1111, 1'b0); end
        for (int i = 0; i < 10; i++) begin rand_ops(); step(4'b1111, 1'b1); end
        for (int i = 0; i < 5; i++)  begin rand_ops(); step(4'b1111, 1'b0); end
        repeat (6) step(4'b0000, 1'b0);

        // Reset with operations in flight.
        for (int i = 0; i < 3; i++) begin rand_ops(); step(4'b0110, 1'b0); end
        rst_n = 1'b0;
        req_valid = '0;
        #1;
        chk("midrst_busy", 32'(busy), 32'd0);
        chk("midrst_resp_valid", 32'(resp_valid), 32'd0);
        @(posedge clk);
        cyc++;
        @(negedge clk);
        rst_n = 1'b1;
        q.delete();
        mptr = 0;
        mstate = 0;
        repeat (6) step(4'b0000, 1'b0);
        rand_ops();
        step(4'b1111, 1'b0);
        repeat (6) step(4'b0000, 1'b0);

        // Sparse traffic from requester 3 only.
        for (int i = 0; i < 10; i++) begin
            rand_ops();
            step((i % 2 == 0) ? 4'b1000 : 4'b0000, 1'b0);
        end
        repeat (6) step(4'b0000, 1'b0);

        // Requesters 0 and 1 contending.
        for (int i = 0; i < 3; i++) begin rand_ops(); step(4'b0011, 1'b0); end
        repeat (6) step(4'b0000, 1'b0);

        // Random traffic with occasional drain toggles.
        d_rand = 1'b0;
        for (int i = 0; i < 400; i++) begin
            rand_ops();
            if ($urandom_range(0, 24) == 0) d_rand = ~d_rand;
            step(4'($urandom_range(0, 15)), d_rand);
        end
        repeat (8) step(4'b0000, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
